// File: rtl/ans_sched_pkg.sv
// ============================================================================
// Module      : ans_sched_pkg
// Description : Shared types, default constants and round-robin helper for
//               the ANS decode scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ans_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int C_NUM_CH          = 4;
    localparam int C_BITSTREAM_WIDTH = 32;
    localparam int C_CONTEXT_WIDTH   = 4;
    localparam int C_SYNTAX_WIDTH    = 16;
    localparam int C_LEN_WIDTH       = 12;
    localparam int C_FLUSH_CYCLES    = 2;
    localparam int C_TIMEOUT         = 1024;

    // Upper bound on channel count the search helper can handle.
    localparam int C_MAX_CH   = 32;
    localparam int C_MAX_CH_W = 5;

    // First requester at or after ptr, wrapping modulo num_ch; -1 if none.
    function automatic int next_grant(input logic [C_MAX_CH-1:0] req,
                                      input int                  num_ch,
                                      input int                  ptr);
        int idx;
        next_grant = -1;
        for (int k = C_MAX_CH - 1; k >= 0; k--) begin
            if (k < num_ch) begin
                idx = ptr + k;
                if (idx >= num_ch) begin
                    idx = idx - num_ch;
                end
                if (req[idx[C_MAX_CH_W-1:0]]) begin
                    next_grant = idx;
                end
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/ans_decode_scheduler_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search from a priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import ans_sched_pkg::*;
#(
    parameter  int NUM_CH = C_NUM_CH,
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic              grant_valid_o
);

    logic [C_MAX_CH-1:0] w_req_ext;
    int                  w_sel;

    always_comb begin
        w_req_ext               = '0;
        w_req_ext[NUM_CH-1:0]   = req_i;
        w_sel                   = next_grant(w_req_ext, NUM_CH, int'(ptr_i));
        grant_valid_o           = (w_sel >= 0);
        grant_idx_o             = grant_valid_o ? IDX_W'(w_sel) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/ans_decode_scheduler.sv
// ============================================================================
// Module      : ans_decode_scheduler
// Description : Job-based round-robin time-sharing of one ANS decoder among
//               NUM_CH bitstream channels, with flush and watchdog abort.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ans_decode_scheduler
    import ans_sched_pkg::*;
#(
    parameter  int NUM_CH          = C_NUM_CH,
    parameter  int BITSTREAM_WIDTH = C_BITSTREAM_WIDTH,
    parameter  int CONTEXT_WIDTH   = C_CONTEXT_WIDTH,
    parameter  int SYNTAX_WIDTH    = C_SYNTAX_WIDTH,
    parameter  int LEN_WIDTH       = C_LEN_WIDTH,
    parameter  int FLUSH_CYCLES    = C_FLUSH_CYCLES,
    parameter  int TIMEOUT         = C_TIMEOUT,
    localparam int IDX_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 ch_req,
    input  logic [NUM_CH*LEN_WIDTH-1:0]       ch_len,
    input  logic [NUM_CH*BITSTREAM_WIDTH-1:0] ch_bitstream,
    input  logic [NUM_CH-1:0]                 ch_bs_valid,
    input  logic [NUM_CH*CONTEXT_WIDTH-1:0]   ch_context,
    output logic [NUM_CH-1:0]                 ch_data_request,
    output logic [NUM_CH-1:0]                 ch_syntax_valid,
    output logic [NUM_CH-1:0]                 ch_done,
    output logic                              ch_error,
    output logic [SYNTAX_WIDTH-1:0]           syntax_element,
    output logic                              dec_rst,
    output logic [BITSTREAM_WIDTH-1:0]        dec_bitstream,
    output logic                              dec_bitstream_valid,
    output logic [CONTEXT_WIDTH-1:0]          dec_context,
    output logic                              dec_ready,
    input  logic                              dec_data_request,
    input  logic [SYNTAX_WIDTH-1:0]           dec_syntax_element,
    input  logic                              dec_syntax_valid,
    output logic                              busy,
    output logic [IDX_W-1:0]                  grant_id
);

    localparam int IDLE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    sched_state_t         state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] elem_cnt_q, elem_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                 abort_q, abort_d;
    logic                 dec_ready_q;

    logic [IDX_W-1:0]           w_arb_idx;
    logic                       w_arb_valid;
    logic [BITSTREAM_WIDTH-1:0] w_bs  [NUM_CH];
    logic [CONTEXT_WIDTH-1:0]   w_ctx [NUM_CH];
    logic [LEN_WIDTH-1:0]       w_len [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign w_bs[i]  = ch_bitstream[i*BITSTREAM_WIDTH +: BITSTREAM_WIDTH];
        assign w_ctx[i] = ch_context[i*CONTEXT_WIDTH +: CONTEXT_WIDTH];
        assign w_len[i] = ch_len[i*LEN_WIDTH +: LEN_WIDTH];
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i         (ch_req),
        .ptr_i         (rr_ptr_q),
        .grant_idx_o   (w_arb_idx),
        .grant_valid_o (w_arb_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            len_q       <= '0;
            elem_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            flush_cnt_q <= '0;
            abort_q     <= 1'b0;
            dec_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            len_q       <= len_d;
            elem_cnt_q  <= elem_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            abort_q     <= abort_d;
            dec_ready_q <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        len_d       = len_q;
        elem_cnt_d  = elem_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        flush_cnt_d = flush_cnt_q;
        abort_d     = abort_q;
        case (state_q)
            IDLE: begin
                if (w_arb_valid) begin
                    grant_d     = w_arb_idx;
                    len_d       = w_len[w_arb_idx];
                    elem_cnt_d  = '0;
                    idle_cnt_d  = '0;
                    flush_cnt_d = '0;
                    abort_d     = 1'b0;
                    state_d     = (w_len[w_arb_idx] == '0) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                elem_cnt_d = '0;
                idle_cnt_d = '0;
                if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            RUN: begin
                // An element arriving on the watchdog's last cycle still counts.
                if (dec_syntax_valid) begin
                    elem_cnt_d = elem_cnt_q + LEN_WIDTH'(1);
                    idle_cnt_d = '0;
                    if ((elem_cnt_q + LEN_WIDTH'(1)) == len_q) begin
                        state_d = DONE;
                    end
                end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            DONE: begin
                rr_ptr_d = (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_data_request     = '0;
        ch_syntax_valid     = '0;
        ch_done             = '0;
        ch_error            = 1'b0;
        syntax_element      = '0;
        dec_bitstream       = '0;
        dec_bitstream_valid = 1'b0;
        dec_context         = '0;
        if (state_q == RUN) begin
            dec_bitstream            = w_bs[grant_q];
            dec_context              = w_ctx[grant_q];
            dec_bitstream_valid      = ch_bs_valid[grant_q];
            ch_data_request[grant_q] = dec_data_request;
            if (dec_syntax_valid) begin
                ch_syntax_valid[grant_q] = 1'b1;
                syntax_element           = dec_syntax_element;
            end
        end
        if (state_q == DONE) begin
            ch_done[grant_q] = 1'b1;
            ch_error         = abort_q;
        end
    end

    assign dec_rst   = ~rst_n | (state_q == FLUSH);
    assign dec_ready = dec_ready_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_ans_decode_scheduler.sv
// ============================================================================
// Module      : tb_ans_decode_scheduler
// Description : Self-checking bench for ans_decode_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ans_decode_scheduler;

    localparam int NCH = 4;
    localparam int BW  = 32;
    localparam int CW  = 4;
    localparam int SW  = 16;
    localparam int LW  = 12;
    localparam int FC  = 2;
    localparam int TO  = 16;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    ch_req;
    logic [NCH*LW-1:0] ch_len;
    logic [NCH*BW-1:0] ch_bitstream;
    logic [NCH-1:0]    ch_bs_valid;
    logic [NCH*CW-1:0] ch_context;
    logic [NCH-1:0]    ch_data_request;
    logic [NCH-1:0]    ch_syntax_valid;
    logic [NCH-1:0]    ch_done;
    logic              ch_error;
    logic [SW-1:0]     syntax_element;
    logic              dec_rst;
    logic [BW-1:0]     dec_bitstream;
    logic              dec_bitstream_valid;
    logic [CW-1:0]     dec_context;
    logic              dec_ready;
    logic              dec_data_request;
    logic [SW-1:0]     dec_syntax_element;
    logic              dec_syntax_valid;
    logic              busy;
    logic [1:0]        grant_id;

    ans_decode_scheduler #(
        .NUM_CH          (NCH),
        .BITSTREAM_WIDTH (BW),
        .CONTEXT_WIDTH   (CW),
        .SYNTAX_WIDTH    (SW),
        .LEN_WIDTH       (LW),
        .FLUSH_CYCLES    (FC),
        .TIMEOUT         (TO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ch_req              (ch_req),
        .ch_len              (ch_len),
        .ch_bitstream        (ch_bitstream),
        .ch_bs_valid         (ch_bs_valid),
        .ch_context          (ch_context),
        .ch_data_request     (ch_data_request),
        .ch_syntax_valid     (ch_syntax_valid),
        .ch_done             (ch_done),
        .ch_error            (ch_error),
        .syntax_element      (syntax_element),
        .dec_rst             (dec_rst),
        .dec_bitstream       (dec_bitstream),
        .dec_bitstream_valid (dec_bitstream_valid),
        .dec_context         (dec_context),
        .dec_ready           (dec_ready),
        .dec_data_request    (dec_data_request),
        .dec_syntax_element  (dec_syntax_element),
        .dec_syntax_valid    (dec_syntax_valid),
        .busy                (busy),
        .grant_id            (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            ch;
        logic [SW-1:0] data;
    } elem_t;

    typedef struct {
        int   ch;
        logic err;
    } done_t;

    typedef struct {
        logic [NCH-1:0] req;
        int             grant;
    } arb_vec_t;

    int       n_checks = 0;
    int       n_fail   = 0;
    bit       mon_en   = 1'b0;
    elem_t    exp_elem[$];
    done_t    exp_done[$];
    arb_vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] onehot(input int c);
        onehot = NCH'(1) << c;
    endfunction

    function automatic void push_elem(input int c, input logic [SW-1:0] d);
        elem_t e;
        e.ch   = c;
        e.data = d;
        exp_elem.push_back(e);
    endfunction

    function automatic void push_done(input int c, input logic err);
        done_t d;
        d.ch  = c;
        d.err = err;
        exp_done.push_back(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every forwarded element and done pulse must match the queue head.
    always @(negedge clk) begin
        elem_t e;
        done_t d;
        if (mon_en) begin
            if (ch_syntax_valid != '0) begin
                if (exp_elem.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_elem: got ch_syntax_valid=%b, required none", ch_syntax_valid);
                end else begin
                    e = exp_elem.pop_front();
                    chk("elem_ch", 64'(ch_syntax_valid), 64'(onehot(e.ch)));
                    chk("elem_data", 64'(syntax_element), 64'(e.data));
                end
            end
            if (ch_done != '0) begin
                if (exp_done.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got ch_done=%b, required none", ch_done);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_ch", 64'(ch_done), 64'(onehot(d.ch)));
                    chk("done_err", 64'(ch_error), 64'(d.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100us");
        $fatal(1);
    end

    initial begin
        // Arbitration sequence of zero-length jobs starting from rr_ptr=0.
        vecs[0]  = '{4'b1111, 0};
        vecs[1]  = '{4'b1111, 1};
        vecs[2]  = '{4'b1111, 2};
        vecs[3]  = '{4'b1111, 3};
        vecs[4]  = '{4'b1111, 0};
        vecs[5]  = '{4'b0001, 0};
        vecs[6]  = '{4'b0010, 1};
        vecs[7]  = '{4'b1001, 3};
        vecs[8]  = '{4'b0110, 1};
        vecs[9]  = '{4'b1100, 2};
        vecs[10] = '{4'b0100, 2};
        vecs[11] = '{4'b0011, 0};

        rst_n              = 1'b0;
        ch_req             = '0;
        ch_len             = '0;
        ch_bs_valid        = '1;
        dec_data_request   = 1'b1;
        dec_syntax_valid   = 1'b1;
        dec_syntax_element = 16'h5555;
        for (int i = 0; i < NCH; i++) begin
            ch_bitstream[i*BW +: BW] = 32'hB000_0000 + 32'(i);
            ch_context[i*CW +: CW]   = CW'(i + 5);
        end

        // Reset state
        tick;
        tick;
        mon_en = 1'b1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_dec_rst", 64'(dec_rst), 64'(1));
        chk("rst_dec_ready", 64'(dec_ready), 64'(0));
        chk("rst_grant", 64'(grant_id), 64'(0));
        chk("rst_ch_done", 64'(ch_done), 64'(0));
        chk("rst_ch_error", 64'(ch_error), 64'(0));
        chk("rst_data_req", 64'(ch_data_request), 64'(0));
        chk("rst_bs", 64'(dec_bitstream), 64'(0));
        chk("rst_bsv", 64'(dec_bitstream_valid), 64'(0));
        chk("rst_ctx", 64'(dec_context), 64'(0));
        chk("rst_syntax", 64'(syntax_element), 64'(0));

        dec_syntax_valid = 1'b0;
        dec_data_request = 1'b0;
        rst_n            = 1'b1;
        tick;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_dec_rst", 64'(dec_rst), 64'(0));

        // Table-driven round-robin order with zero-length jobs
        for (int i = 0; i < 12; i++) begin
            ch_req = vecs[i].req;
            push_done(vecs[i].grant, 1'b0);
            tick;
            chk("arb_grant", 64'(grant_id), 64'(vecs[i].grant));
            chk("arb_busy", 64'(busy), 64'(1));
            chk("len0_no_flush", 64'(dec_rst), 64'(0));
            ch_req = '0;
            tick;
            chk("arb_back_idle", 64'(busy), 64'(0));
        end

        // Single channel, three elements, decoder emits every other cycle
        ch_len[0*LW +: LW] = 12'd3;
        ch_req             = 4'b0001;
        dec_data_request   = 1'b1;
        dec_syntax_valid   = 1'b1;
        dec_syntax_element = 16'hDEAD;
        tick;
        ch_req             = '0;
        ch_len[0*LW +: LW] = 12'd1;
        chk("flush_rst1", 64'(dec_rst), 64'(1));
        chk("flush_grant", 64'(grant_id), 64'(0));
        chk("flush_no_req", 64'(ch_data_request), 64'(0));
        chk("flush_no_bsv", 64'(dec_bitstream_valid), 64'(0));
        chk("flush_ready", 64'(dec_ready), 64'(0));
        tick;
        chk("flush_rst2", 64'(dec_rst), 64'(1));
        tick;
        chk("run_rst_low", 64'(dec_rst), 64'(0));
        chk("run_ready", 64'(dec_ready), 64'(1));
        for (int c = 0; c < 12; c++) begin
            dec_syntax_valid   = c[0];
            dec_syntax_element = 16'hA000 + 16'(c);
            dec_data_request   = ~c[0];
            if (c[0] && c < 6) begin
                push_elem(0, 16'hA000 + 16'(c));
                if (c == 5) push_done(0, 1'b0);
            end
            #1;
            if (c == 0) begin
                chk("route_req", 64'(ch_data_request), 64'(4'b0001));
                chk("route_bs", 64'(dec_bitstream), 64'(32'hB000_0000));
                chk("route_ctx", 64'(dec_context), 64'(5));
                chk("route_bsv", 64'(dec_bitstream_valid), 64'(1));
            end
            if (c == 5) chk("ready_last_elem", 64'(dec_ready), 64'(1));
            if (c == 6) begin
                chk("done_ready_low", 64'(dec_ready), 64'(0));
                chk("done_no_req", 64'(ch_data_request), 64'(0));
            end
            tick;
        end
        dec_syntax_valid = 1'b0;
        dec_data_request = 1'b0;

        // Channel 2 re-requests during its own DONE while channel 3 requests
        ch_len[2*LW +: LW] = 12'd1;
        ch_len[3*LW +: LW] = 12'd1;
        ch_req             = 4'b0100;
        tick;
        chk("c2_grant", 64'(grant_id), 64'(2));
        ch_req = '0;
        tick;
        tick;
        dec_syntax_valid   = 1'b1;
        dec_syntax_element = 16'h1234;
        push_elem(2, 16'h1234);
        push_done(2, 1'b0);
        tick;
        dec_syntax_valid = 1'b0;
        ch_req           = 4'b1100;
        chk("c2_done", 64'(ch_done), 64'(4'b0100));
        tick;
        tick;
        chk("c3_after_c2", 64'(grant_id), 64'(3));
        chk("c3_flush", 64'(dec_rst), 64'(1));
        ch_req = '0;
        tick;
        tick;
        dec_syntax_valid   = 1'b1;
        dec_syntax_element = 16'h4321;
        push_elem(3, 16'h4321);
        push_done(3, 1'b0);
        tick;
        dec_syntax_valid = 1'b0;
        tick;

        // Watchdog abort with a silent decoder
        ch_len[1*LW +: LW] = 12'd5;
        ch_req             = 4'b0010;
        tick;
        chk("to_grant", 64'(grant_id), 64'(1));
        ch_req             = 4'b1000;
        ch_len[3*LW +: LW] = 12'd8;
        tick;
        tick;
        push_done(1, 1'b1);
        for (int c = 0; c < TO; c++) begin
            chk("to_pending", 64'(ch_done), 64'(0));
            tick;
        end
        chk("to_done", 64'(ch_done), 64'(4'b0010));
        chk("to_err", 64'(ch_error), 64'(1));
        tick;
        tick;
        chk("to_next_grant", 64'(grant_id), 64'(3));

        // Reset asserted mid-job after five elements
        tick;
        tick;
        for (int c = 0; c < 5; c++) begin
            dec_syntax_valid   = 1'b1;
            dec_syntax_element = 16'h7000 + 16'(c);
            push_elem(3, 16'h7000 + 16'(c));
            tick;
        end
        dec_syntax_valid   = 1'b0;
        ch_req             = 4'b1111;
        ch_len[0*LW +: LW] = 12'd3;
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_comb_dec_rst", 64'(dec_rst), 64'(1));
        tick;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_ready", 64'(dec_ready), 64'(0));
        chk("midrst_dec_rst", 64'(dec_rst), 64'(1));
        chk("midrst_no_done", 64'(ch_done), 64'(0));
        rst_n = 1'b1;
        tick;
        chk("rearb_from_0", 64'(grant_id), 64'(0));
        chk("rearb_busy", 64'(busy), 64'(1));
        rst_n  = 1'b0;
        ch_req = '0;
        tick;
        tick;

        chk("elem_queue_empty", 64'(exp_elem.size()), 64'(0));
        chk("done_queue_empty", 64'(exp_done.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
